// File: rtl/unidade_controle_rodadas_if.sv
// unidade_controle_rodadas_if: game-control bus between the round controller and its datapath/test driver
//   Parameter N_JOGADAS sets the address/round width W = $clog2(N_JOGADAS).
//   Driver -> controller : iniciar, modo_exibe, jogada, igual
//   Controller -> driver : endereco[W], rodada[W], zeraR, registraR, exibe_led,
//                          pronto, acertou, errou, timeout, db_estado[4]
//   Modports: master (driver side), slave (controller side).
interface unidade_controle_rodadas_if #(
   parameter int N_JOGADAS = 16
);
   localparam int W = $clog2(N_JOGADAS);
   logic         iniciar;
   logic         modo_exibe;
   logic         jogada;
   logic         igual;
   logic [W-1:0] endereco;
   logic [W-1:0] rodada;
   logic         zeraR;
   logic         registraR;
   logic         exibe_led;
   logic         pronto;
   logic         acertou;
   logic         errou;
   logic         timeout;
   logic [3:0]   db_estado;
   modport master (
      output iniciar, modo_exibe, jogada, igual,
      input  endereco, rodada, zeraR, registraR, exibe_led, pronto, acertou, errou, timeout, db_estado
   );
   modport slave (
      input  iniciar, modo_exibe, jogada, igual,
      output endereco, rodada, zeraR, registraR, exibe_led, pronto, acertou, errou, timeout, db_estado
   );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore round controller for the sequence memory game
//   Ports: clock, reset (synchronous, active-high), uc (unidade_controle_rodadas_if.slave).
//   Owns the address, round and timer counters; optional show phase lights each stored
//   play before the player's turn; reports win, error or timeout.
//   Macro UC_TIMEOUT_EN: defined enables the per-play timeout; undefined makes
//   espera_jogada wait indefinitely and ties timeout to 0.
module unidade_controle_rodadas #(
   parameter int N_JOGADAS      = 16,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int EXIBE_CICLOS   = 1000
)(
   input logic                         clock,
   input logic                         reset,
   unidade_controle_rodadas_if.slave   uc
);
   localparam int W    = $clog2(N_JOGADAS);
   localparam int TMAX = TIMEOUT_CICLOS > EXIBE_CICLOS ? TIMEOUT_CICLOS : EXIBE_CICLOS;
   localparam int WT   = TMAX > 1 ? $clog2(TMAX) : 1;
   localparam logic [3:0] INICIAL        = 4'h0;
   localparam logic [3:0] PREPARACAO     = 4'h1;
   localparam logic [3:0] INICIA_RODADA  = 4'h2;
   localparam logic [3:0] ESPERA_JOGADA  = 4'h3;
   localparam logic [3:0] REGISTRA       = 4'h4;
   localparam logic [3:0] COMPARACAO     = 4'h5;
   localparam logic [3:0] PROXIMO        = 4'h6;
   localparam logic [3:0] ULTIMA_RODADA  = 4'h7;
   localparam logic [3:0] PROXIMA_RODADA = 4'h8;
   localparam logic [3:0] EXIBE          = 4'h9;
   localparam logic [3:0] FIM_ACERTOU    = 4'hA;
   localparam logic [3:0] EXIBE_PROX     = 4'hB;
   localparam logic [3:0] FIM_TIMEOUT    = 4'hC;
   localparam logic [3:0] FIM_ERROU      = 4'hE;
   logic [3:0]    estado_q, estado_d;
   logic [W-1:0]  endereco_q, endereco_d;
   logic [W-1:0]  rodada_q, rodada_d;
   logic [WT-1:0] timer_q, timer_d;
   logic          fim_exibe, fim_espera, ultimo_end, ultima_rod;
   assign fim_exibe  = timer_q == WT'(EXIBE_CICLOS - 1);
`ifdef UC_TIMEOUT_EN
   assign fim_espera = timer_q == WT'(TIMEOUT_CICLOS - 1);
`else
   assign fim_espera = 1'b0;
`endif
   assign ultimo_end = endereco_q == rodada_q;
   assign ultima_rod = rodada_q == W'(N_JOGADAS - 1);
   // Timer saturates at its terminal count; the state always leaves on that cycle anyway.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      rodada_d   = rodada_q;
      timer_d    = timer_q;
      case (estado_q)
         INICIAL: estado_d = uc.iniciar ? PREPARACAO : INICIAL;
         PREPARACAO: begin
            rodada_d   = '0;
            endereco_d = '0;
            timer_d    = '0;
            estado_d   = INICIA_RODADA;
         end
         INICIA_RODADA: begin
            endereco_d = '0;
            timer_d    = '0;
            estado_d   = uc.modo_exibe ? EXIBE : ESPERA_JOGADA;
         end
         EXIBE: begin
            timer_d  = fim_exibe ? timer_q : timer_q + 1'b1;
            estado_d = fim_exibe ? EXIBE_PROX : EXIBE;
         end
         EXIBE_PROX: begin
            timer_d    = '0;
            endereco_d = ultimo_end ? '0 : endereco_q + 1'b1;
            estado_d   = ultimo_end ? ESPERA_JOGADA : EXIBE;
         end
         ESPERA_JOGADA: begin
`ifdef UC_TIMEOUT_EN
            timer_d  = fim_espera ? timer_q : timer_q + 1'b1;
`endif
            // A press on the terminal cycle still counts as a play.
            estado_d = uc.jogada ? REGISTRA : fim_espera ? FIM_TIMEOUT : ESPERA_JOGADA;
         end
         REGISTRA: estado_d = COMPARACAO;
         COMPARACAO: estado_d = !uc.igual ? FIM_ERROU : ultimo_end ? ULTIMA_RODADA : PROXIMO;
         PROXIMO: begin
            endereco_d = endereco_q + 1'b1;
            timer_d    = '0;
            estado_d   = ESPERA_JOGADA;
         end
         ULTIMA_RODADA: estado_d = ultima_rod ? FIM_ACERTOU : PROXIMA_RODADA;
         PROXIMA_RODADA: begin
            rodada_d = rodada_q + 1'b1;
            estado_d = INICIA_RODADA;
         end
         FIM_ERROU, FIM_ACERTOU, FIM_TIMEOUT: estado_d = uc.iniciar ? PREPARACAO : estado_q;
         default: estado_d = INICIAL;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= INICIAL;
         endereco_q <= '0;
         rodada_q   <= '0;
         timer_q    <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         rodada_q   <= rodada_d;
         timer_q    <= timer_d;
      end
   end
   assign uc.endereco  = endereco_q;
   assign uc.rodada    = rodada_q;
   assign uc.zeraR     = estado_q == INICIAL || estado_q == PREPARACAO;
   assign uc.registraR = estado_q == REGISTRA;
   assign uc.exibe_led = estado_q == EXIBE;
   assign uc.pronto    = estado_q == FIM_ERROU || estado_q == FIM_ACERTOU || estado_q == FIM_TIMEOUT;
   assign uc.acertou   = estado_q == FIM_ACERTOU;
   assign uc.errou     = estado_q == FIM_ERROU;
`ifdef UC_TIMEOUT_EN
   assign uc.timeout   = estado_q == FIM_TIMEOUT;
`else
   assign uc.timeout   = 1'b0;
`endif
   // Only 0xD and 0xF are unused codes; both report F for their single cycle.
   assign uc.db_estado = estado_q == 4'hD ? 4'hF : estado_q;
endmodule
